// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : Run/set mode sequencer for the digital clock. Synchronises the
//            MODE and SET buttons, steps RUN -> SET_HOUR -> SET_MIN ->
//            SET_SEC -> RUN, gates the seconds counter, issues one-cycle
//            hour/minute increment and seconds-clear pulses, and produces
//            blink strobes for the digits being adjusted.
// Options  : define SET_AUTOREPEAT_EN to enable auto-repeat of the hour and
//            minute increment while SET is held.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int BLINK_DIV   = 12500000,  // cycles per blink half-period
  parameter int REPEAT_DLY  = 25000000,  // hold time before first repeat
  parameter int REPEAT_RATE = 5000000    // cycles between later repeats
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEC_PULSE,
  input  logic       BTN_MODE,
  input  logic       BTN_SET,
  output logic       SEC_EN,
  output logic       SEC_CLR,
  output logic       MIN_INC,
  output logic       HOUR_INC,
  output logic       BLINK_HOUR,
  output logic       BLINK_MIN,
  output logic [1:0] MODE
);

  // Both internal counters are 25 bits wide, enough for every legal setting.
  localparam int              c_CNT_W      = 25;
  localparam int              c_CNT_MAX    = (1 << c_CNT_W) - 1;
  localparam logic [c_CNT_W-1:0] c_BLINK_LAST = c_CNT_W'(BLINK_DIV - 1);

  // Reject out-of-range configurations at elaboration time.
  if (BLINK_DIV < 2 || BLINK_DIV > c_CNT_MAX) begin : g_chk_blink_div
    $error("clock_set_ctrl: BLINK_DIV out of range 2..2^25-1");
  end
  if (REPEAT_DLY < 2 || REPEAT_DLY > c_CNT_MAX) begin : g_chk_repeat_dly
    $error("clock_set_ctrl: REPEAT_DLY out of range 2..2^25-1");
  end
  if (REPEAT_RATE < 2 || REPEAT_RATE > c_CNT_MAX) begin : g_chk_repeat_rate
    $error("clock_set_ctrl: REPEAT_RATE out of range 2..2^25-1");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic mode_s1_q, mode_s2_q;
  logic set_s1_q,  set_s2_q;

  logic [c_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q,  blink_ph_d;
  logic               blink_hour_q, blink_min_q;

  logic sec_clr_q, min_inc_q, hour_inc_q;

  logic w_mode_press;
  logic w_set_press;
  logic w_set_act;
  logic w_rpt_hour;
  logic w_rpt_min;

  // Two-flop input path for both buttons; history is cleared by reset so a
  // button held through reset release shows up as a fresh press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      set_s1_q  <= 1'b0;
      set_s2_q  <= 1'b0;
    end else begin
      mode_s1_q <= BTN_MODE;
      mode_s2_q <= mode_s1_q;
      set_s1_q  <= BTN_SET;
      set_s2_q  <= set_s1_q;
    end
  end

  // Rising-edge detect; a MODE press swallows a SET press in the same cycle.
  assign w_mode_press = mode_s1_q & ~mode_s2_q;
  assign w_set_press  = set_s1_q  & ~set_s2_q;
  assign w_set_act    = w_set_press & ~w_mode_press;

  // Mode state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode: advance one step on every MODE press.
  always_comb begin
    state_d = state_q;
    if (w_mode_press) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_SET_SEC;
        ST_SET_SEC:  state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

`ifdef SET_AUTOREPEAT_EN
  // Auto-repeat: while SET stays held in an hour/minute set state, count the
  // hold time. The first repeat fires once the count reaches REPEAT_DLY,
  // later ones every REPEAT_RATE cycles. rpt_arm_q marks the second phase.
  logic [c_CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic               rpt_arm_q, rpt_arm_d;
  logic               w_rpt_hold;
  logic               w_rpt_fire;

  localparam logic [c_CNT_W-1:0] c_RPT_DLY  = c_CNT_W'(REPEAT_DLY);
  localparam logic [c_CNT_W-1:0] c_RPT_RATE = c_CNT_W'(REPEAT_RATE);

  assign w_rpt_hold = set_s2_q & ~w_mode_press &
                      ((state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN));

  // Repeat counter next state and fire decision.
  always_comb begin
    rpt_cnt_d  = '0;
    rpt_arm_d  = 1'b0;
    w_rpt_fire = 1'b0;
    if (w_rpt_hold) begin
      if ((!rpt_arm_q && rpt_cnt_q == c_RPT_DLY) ||
          ( rpt_arm_q && rpt_cnt_q == c_RPT_RATE)) begin
        w_rpt_fire = 1'b1;
        rpt_cnt_d  = c_CNT_W'(1);
        rpt_arm_d  = 1'b1;
      end else begin
        rpt_cnt_d  = rpt_cnt_q + 1'b1;
        rpt_arm_d  = rpt_arm_q;
      end
    end
  end

  // Repeat counter register; releasing SET or leaving the state clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end

  assign w_rpt_hour = w_rpt_fire & (state_q == ST_SET_HOUR);
  assign w_rpt_min  = w_rpt_fire & (state_q == ST_SET_MIN);
`else
  // Without auto-repeat every press yields exactly one pulse.
  assign w_rpt_hour = 1'b0;
  assign w_rpt_min  = 1'b0;
`endif

  // Registered one-cycle pulses toward the time counter chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hour_inc_q <= 1'b0;
      min_inc_q  <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      hour_inc_q <= (w_set_act & (state_q == ST_SET_HOUR)) | w_rpt_hour;
      min_inc_q  <= (w_set_act & (state_q == ST_SET_MIN))  | w_rpt_min;
      sec_clr_q  <=  w_set_act & (state_q == ST_SET_SEC);
    end
  end

  // Blink divider next state; restarts lit on every mode change.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == c_BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // Blink divider and registered per-digit blank strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      blink_hour_q <= 1'b0;
      blink_min_q  <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      blink_hour_q <= (state_d == ST_SET_HOUR) & blink_ph_d;
      blink_min_q  <= (state_d == ST_SET_MIN)  & blink_ph_d;
    end
  end

  // Seconds run only in RUN; ticks arriving in any set state are dropped.
  assign SEC_EN     = (state_q == ST_RUN) & SEC_PULSE;
  assign SEC_CLR    = sec_clr_q;
  assign MIN_INC    = min_inc_q;
  assign HOUR_INC   = hour_inc_q;
  assign BLINK_HOUR = blink_hour_q;
  assign BLINK_MIN  = blink_min_q;
  assign MODE       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Brief    : Directed self-checking bench for clock_set_ctrl with
//            BLINK_DIV=4, REPEAT_DLY=8, REPEAT_RATE=3. Inputs change on the
//            falling edge, outputs are sampled 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SEC_PULSE;
  logic       BTN_MODE;
  logic       BTN_SET;
  logic       SEC_EN, SEC_CLR, MIN_INC, HOUR_INC, BLINK_HOUR, BLINK_MIN;
  logic [1:0] MODE;

  int tests_run    = 0;
  int tests_failed = 0;

  // Pulse bookkeeping filled by the monitor below.
  int   min_cnt = 0, hour_cnt = 0, clr_cnt = 0, dbl_cnt = 0;
  logic prev_min = 1'b0, prev_hour = 1'b0, prev_clr = 1'b0;

  clock_set_ctrl #(
    .BLINK_DIV  (4),
    .REPEAT_DLY (8),
    .REPEAT_RATE(3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SEC_PULSE (SEC_PULSE),
    .BTN_MODE  (BTN_MODE),
    .BTN_SET   (BTN_SET),
    .SEC_EN    (SEC_EN),
    .SEC_CLR   (SEC_CLR),
    .MIN_INC   (MIN_INC),
    .HOUR_INC  (HOUR_INC),
    .BLINK_HOUR(BLINK_HOUR),
    .BLINK_MIN (BLINK_MIN),
    .MODE      (MODE)
  );

  always #5 CLK = ~CLK;

  // Count pulses and catch any pulse lasting two consecutive cycles.
  always @(negedge CLK) begin
    if (MIN_INC)  min_cnt  = min_cnt + 1;
    if (HOUR_INC) hour_cnt = hour_cnt + 1;
    if (SEC_CLR)  clr_cnt  = clr_cnt + 1;
    if ((MIN_INC && prev_min) || (HOUR_INC && prev_hour) || (SEC_CLR && prev_clr))
      dbl_cnt = dbl_cnt + 1;
    prev_min  = MIN_INC;
    prev_hour = HOUR_INC;
    prev_clr  = SEC_CLR;
  end

  task automatic clear_counts();
    min_cnt = 0; hour_cnt = 0; clr_cnt = 0; dbl_cnt = 0;
  endtask

  // Drive a button combination for 'hold' cycles, then idle 'gap' cycles.
  task automatic press(input logic m, input logic s, input int hold, input int gap);
    @(negedge CLK);
    BTN_MODE = m;
    BTN_SET  = s;
    repeat (hold) @(negedge CLK);
    BTN_MODE = 1'b0;
    BTN_SET  = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic exp_en;
    RST = 1'b1; SEC_PULSE = 1'b0; BTN_MODE = 1'b0; BTN_SET = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    tests_run++;
    if (MODE !== 2'd0) begin
      tests_failed++; $display("FAIL reset_mode: got %0d expected 0", MODE);
    end
    tests_run++;
    if ({SEC_CLR, MIN_INC, HOUR_INC, BLINK_HOUR, BLINK_MIN} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {SEC_CLR, MIN_INC, HOUR_INC, BLINK_HOUR, BLINK_MIN});
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      exp_en    = (i % 10 == 0);
      SEC_PULSE = exp_en;
      #1;
      tests_run++;
      if (SEC_EN !== exp_en) begin
        tests_failed++; $display("FAIL run_sec_en[%0d]: got %b expected %b", i, SEC_EN, exp_en);
      end
      tests_run++;
      if ({MODE, SEC_CLR, MIN_INC, HOUR_INC, BLINK_HOUR, BLINK_MIN} !== 7'b0) begin
        tests_failed++;
        $display("FAIL run_idle[%0d]: got %b expected 0000000", i,
                 {MODE, SEC_CLR, MIN_INC, HOUR_INC, BLINK_HOUR, BLINK_MIN});
      end
    end
    SEC_PULSE = 1'b0;
  endtask

  task automatic test_mode_seq();
    logic [1:0] exp_mode;
    logic       exp_en;
    exp_mode = 2'd0;
    for (int p = 0; p < 4; p++) begin
      @(negedge CLK);
      BTN_MODE  = 1'b1;
      SEC_PULSE = 1'b0;
      for (int c = 1; c < 20; c++) begin
        @(negedge CLK);
        if (c == 3) BTN_MODE = 1'b0;
        SEC_PULSE = (c % 5 == 0);
        if (c == 2) exp_mode = 2'(p + 1);
        #1;
        exp_en = (exp_mode == 2'd0) && (c % 5 == 0);
        tests_run++;
        if (MODE !== exp_mode) begin
          tests_failed++;
          $display("FAIL mode_seq[%0d.%0d]: got %0d expected %0d", p, c, MODE, exp_mode);
        end
        tests_run++;
        if (SEC_EN !== exp_en) begin
          tests_failed++;
          $display("FAIL mode_sec_en[%0d.%0d]: got %b expected %b", p, c, SEC_EN, exp_en);
        end
      end
    end
    SEC_PULSE = 1'b0;
  endtask

  task automatic test_set_pulses();
    press(1'b1, 1'b0, 3, 5);
    press(1'b1, 1'b0, 3, 5);
    #1;
    tests_run++;
    if (MODE !== 2'd2) begin
      tests_failed++; $display("FAIL enter_set_min: got %0d expected 2", MODE);
    end
    clear_counts();
    // First SET press: pulse on the second edge after the button rises.
    @(negedge CLK); BTN_SET = 1'b1;
    @(negedge CLK); #1;
    tests_run++;
    if (MIN_INC !== 1'b0) begin
      tests_failed++; $display("FAIL min_inc_early: got %b expected 0", MIN_INC);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (MIN_INC !== 1'b1) begin
      tests_failed++; $display("FAIL min_inc_latency: got %b expected 1", MIN_INC);
    end
    @(negedge CLK); BTN_SET = 1'b0; #1;
    tests_run++;
    if (MIN_INC !== 1'b0) begin
      tests_failed++; $display("FAIL min_inc_width: got %b expected 0", MIN_INC);
    end
    repeat (5) @(negedge CLK);
    press(1'b0, 1'b1, 3, 6);
    press(1'b0, 1'b1, 3, 6);
    #1;
    tests_run++;
    if (min_cnt !== 3 || dbl_cnt !== 0) begin
      tests_failed++;
      $display("FAIL min_inc_count: got %0d pulses (%0d doubled) expected 3 (0)", min_cnt, dbl_cnt);
    end
    tests_run++;
    if (hour_cnt !== 0 || clr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL set_min_other: got hour=%0d clr=%0d expected 0 0", hour_cnt, clr_cnt);
    end
    press(1'b1, 1'b0, 3, 5);
    #1;
    tests_run++;
    if (MODE !== 2'd3) begin
      tests_failed++; $display("FAIL enter_set_sec: got %0d expected 3", MODE);
    end
    clear_counts();
    press(1'b0, 1'b1, 3, 6);
    #1;
    tests_run++;
    if (clr_cnt !== 1 || min_cnt !== 0 || hour_cnt !== 0 || dbl_cnt !== 0) begin
      tests_failed++;
      $display("FAIL sec_clr_pulse: got clr=%0d min=%0d hour=%0d dbl=%0d expected 1 0 0 0",
               clr_cnt, min_cnt, hour_cnt, dbl_cnt);
    end
    press(1'b1, 1'b0, 3, 5);
    #1;
    tests_run++;
    if (MODE !== 2'd0) begin
      tests_failed++; $display("FAIL back_to_run: got %0d expected 0", MODE);
    end
    clear_counts();
    press(1'b0, 1'b1, 3, 6);
    #1;
    tests_run++;
    if (clr_cnt + min_cnt + hour_cnt !== 0) begin
      tests_failed++;
      $display("FAIL run_set_ignored: got %0d pulses expected 0", clr_cnt + min_cnt + hour_cnt);
    end
  endtask

  task automatic test_blink();
    logic exp_bh;
    @(negedge CLK); BTN_MODE = 1'b1;
    @(negedge CLK); #1;
    tests_run++;
    if (MODE !== 2'd0) begin
      tests_failed++; $display("FAIL blink_entry_early: got %0d expected 0", MODE);
    end
    @(negedge CLK); BTN_MODE = 1'b0; #1;
    tests_run++;
    if (MODE !== 2'd1) begin
      tests_failed++; $display("FAIL blink_entry: got %0d expected 1", MODE);
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(negedge CLK); #1;
      end
      exp_bh = ((i / 4) % 2 == 1);
      tests_run++;
      if (BLINK_HOUR !== exp_bh || BLINK_MIN !== 1'b0) begin
        tests_failed++;
        $display("FAIL blink_hour[%0d]: got hour=%b min=%b expected hour=%b min=0",
                 i, BLINK_HOUR, BLINK_MIN, exp_bh);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    press(1'b1, 1'b1, 3, 6);
    #1;
    tests_run++;
    if (MODE !== 2'd2) begin
      tests_failed++; $display("FAIL simul_mode: got %0d expected 2", MODE);
    end
    tests_run++;
    if (hour_cnt !== 0 || min_cnt !== 0) begin
      tests_failed++;
      $display("FAIL simul_no_pulse: got hour=%0d min=%0d expected 0 0", hour_cnt, min_cnt);
    end
  endtask

  task automatic test_autorepeat();
    int got_q[$];
    int exp_q[$];
`ifdef SET_AUTOREPEAT_EN
    exp_q = '{2, 11, 14, 17, 20};
`else
    exp_q = '{2};
`endif
    clear_counts();
    @(negedge CLK); BTN_SET = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (i == 20) BTN_SET = 1'b0;
      #1;
      if (MIN_INC === 1'b1) got_q.push_back(i);
    end
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL repeat_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size()) begin
        tests_run++;
        if (got_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL repeat_pos[%0d]: got cycle %0d expected %0d", k, got_q[k], exp_q[k]);
        end
      end
    end
    tests_run++;
    if (hour_cnt !== 0 || dbl_cnt !== 0) begin
      tests_failed++;
      $display("FAIL repeat_other: got hour=%0d dbl=%0d expected 0 0", hour_cnt, dbl_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge CLK); BTN_SET = 1'b1;
    @(negedge CLK); #1;
    w = 0;
    while (BLINK_MIN !== 1'b1 && w < 12) begin
      @(negedge CLK); #1;
      w++;
    end
    tests_run++;
    if (w >= 12) begin
      tests_failed++; $display("FAIL blink_min_timeout: got no blink in %0d cycles expected <12", w);
    end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    tests_run++;
    if (MODE !== 2'd0 || BLINK_MIN !== 1'b0 || MIN_INC !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got mode=%0d blink_min=%b min_inc=%b expected 0 0 0",
               MODE, BLINK_MIN, MIN_INC);
    end
    clear_counts();
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK); #1;
      tests_run++;
      if (MODE !== 2'd0 || BLINK_MIN !== 1'b0 || BLINK_HOUR !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_idle[%0d]: got mode=%0d bm=%b bh=%b expected 0 0 0",
                 i, MODE, BLINK_MIN, BLINK_HOUR);
      end
    end
    BTN_SET = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    tests_run++;
    if (min_cnt + hour_cnt + clr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_pulses: got %0d expected 0", min_cnt + hour_cnt + clr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mode_seq();
    test_set_pulses();
    test_blink();
    test_simultaneous();
    test_autorepeat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
